// File: rtl/riscv_boot_pkg.sv
// ---------------------------------------------------------------------------
// riscv_boot_pkg
// Shared definitions for the riscv boot/run sequencer.
//   state_t        : controller state encoding (IDLE, LOAD, FLUSH, RUN, DONE)
//   BYTES_PER_WORD : bytes streamed per instruction word
//   lenWidth()     : width of the word-count field for a given address width
// ---------------------------------------------------------------------------
package riscv_boot_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_LOAD  = 3'd1;
    localparam state_t ST_FLUSH = 3'd2;
    localparam state_t ST_RUN   = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    localparam int BYTES_PER_WORD = 4;

    // One extra bit so a full memory (2^addrW words) is representable.
    function automatic int lenWidth(input int addrW);
        return addrW + 1;
    endfunction

endpackage

// File: rtl/riscv_boot_ctrl_byte_packer.sv
// ---------------------------------------------------------------------------
// byte_packer
// Assembles a byte stream into 32-bit little-endian words.
//   clk_i       : clock, rising edge
//   rst_i       : synchronous active-high reset
//   clr_i       : drops any partial word and restarts at byte lane 0
//   push_i      : accept byte_in_i into the current lane
//   byte_in_i   : byte data
//   word_out_o  : assembled word (valid while word_done_o is high)
//   word_done_o : registered pulse, high the cycle after the 4th byte
//   last_lane_o : the next push completes a word
// ---------------------------------------------------------------------------
module byte_packer
    import riscv_boot_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        push_i,
    input  logic [7:0]  byte_in_i,
    output logic [31:0] word_out_o,
    output logic        word_done_o,
    output logic        last_lane_o
);

    localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  byteCnt_q, byteCnt_d;
    logic [31:0] word_q, word_d;
    logic        done_q, done_d;

    // Next-state for the lane counter and assembly register. The byte lands
    // in the lane given by the counter, so byte 0 ends up in [7:0]. The
    // done pulse is raised together with the final lane write so that the
    // word and its strobe appear on the same following cycle.
    always_comb begin
        byteCnt_d = byteCnt_q;
        word_d    = word_q;
        done_d    = 1'b0;
        if (clr_i) begin
            byteCnt_d = '0;
            word_d    = '0;
        end else if (push_i) begin
            word_d[8*byteCnt_q +: 8] = byte_in_i;
            byteCnt_d                = byteCnt_q + 2'd1;
            done_d                   = (byteCnt_q == LAST_LANE);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            byteCnt_q <= '0;
            word_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            byteCnt_q <= byteCnt_d;
            word_q    <= word_d;
            done_q    <= done_d;
        end
    end

    assign word_out_o  = word_q;
    assign word_done_o = done_q;
    assign last_lane_o = (byteCnt_q == LAST_LANE);

endmodule

// File: rtl/riscv_boot_ctrl.sv
// ---------------------------------------------------------------------------
// riscv_boot_ctrl
// Boot and run sequencer for the single-cycle riscv core: holds the core in
// reset, streams bytes into instruction memory as little-endian words, then
// releases the core for RUN_CYCLES cycles and reports completion.
//   clk_i, rst_i : clock and synchronous active-high reset
//   start_i      : start pulse, accepted in IDLE or DONE
//   len_i        : number of words to load, sampled on start
//   abort_i      : terminates LOAD, FLUSH or RUN
//   s_valid_i / s_data_i / s_ready_o : byte stream handshake
//   mem_we_o / mem_addr_o / mem_wdata_o : instruction memory write port
//   core_rst_o   : active-high reset to the core
//   busy_o       : in LOAD, FLUSH or RUN
//   done_o       : in DONE
//   err_o        : sticky error, cleared by the next accepted start
//   cycles_o     : RUN cycles elapsed in the current or last run
// ---------------------------------------------------------------------------
module riscv_boot_ctrl
    import riscv_boot_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int RUN_CYCLES = 100
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W:0]   len_i,
    input  logic              abort_i,
    input  logic              s_valid_i,
    input  logic [7:0]        s_data_i,
    output logic              s_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              core_rst_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [15:0]       cycles_o
);

    localparam int              LEN_W   = lenWidth(ADDR_W);
    localparam logic [LEN_W-1:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0] wordCnt_q, wordCnt_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic              coreRst_q, coreRst_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [15:0]       cycles_q, cycles_d;

    logic              abortNow;
    logic              startNow;
    logic              push;
    logic              lastLane;
    logic              wordHs;

    // Decoded handshakes. Abort only matters while busy, so a simultaneous
    // start in IDLE/DONE is handled normally. A byte offered in the abort
    // cycle is dropped so no new write gets scheduled behind the abort.
    assign s_ready_o = (state_q == ST_LOAD);
    assign busy_o    = (state_q == ST_LOAD) || (state_q == ST_FLUSH) || (state_q == ST_RUN);
    assign abortNow  = abort_i && busy_o;
    assign startNow  = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign push      = s_ready_o && s_valid_i && !abortNow;
    assign wordHs    = push && lastLane;

    byte_packer uPacker (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (abortNow || startNow),
        .push_i      (push),
        .byte_in_i   (s_data_i),
        .word_out_o  (mem_wdata_o),
        .word_done_o (mem_we_o),
        .last_lane_o (lastLane)
    );

    // Controller next-state. The cycle counter advances on every RUN cycle,
    // including one that is being aborted, so the held value equals the
    // number of cycles the core actually ran. The write address is captured
    // on the word-completing handshake so it lines up with the packer's
    // registered strobe; an abort leaves it alone so a pending write lands.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        wordCnt_d = wordCnt_q;
        memAddr_d = memAddr_q;
        err_d     = err_q;
        cycles_d  = cycles_q;

        if (state_q == ST_RUN && cycles_q != 16'hFFFF) begin
            cycles_d = cycles_q + 16'd1;
        end

        if (abortNow) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        if (len_i > MAX_LEN) begin
                            err_d   = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            err_d     = 1'b0;
                            cycles_d  = '0;
                            wordCnt_d = '0;
                            len_d     = len_i;
                            state_d   = (len_i == '0) ? ST_RUN : ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (wordHs) begin
                        memAddr_d = wordCnt_q;
                        wordCnt_d = wordCnt_q + 1'b1;
                        if ({1'b0, wordCnt_q} == len_q - 1'b1) begin
                            state_d = ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (int'(cycles_q) + 1 >= RUN_CYCLES) begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        coreRst_d = (state_d != ST_RUN);
        done_d    = (state_d == ST_DONE);
    end

    // State and registered outputs, synchronous reset overriding everything.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            wordCnt_q <= '0;
            memAddr_q <= '0;
            coreRst_q <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cycles_q  <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            wordCnt_q <= wordCnt_d;
            memAddr_q <= memAddr_d;
            coreRst_q <= coreRst_d;
            done_q    <= done_d;
            err_q     <= err_d;
            cycles_q  <= cycles_d;
        end
    end

    assign mem_addr_o = memAddr_q;
    assign core_rst_o = coreRst_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign cycles_o   = cycles_q;

endmodule

// File: tb/tb_riscv_boot_ctrl.sv
// ---------------------------------------------------------------------------
// tb_riscv_boot_ctrl
// Directed sequence with random byte data and random stalls, checked against
// a word-level memory model built from the bytes the bench sent.
// ---------------------------------------------------------------------------
module tb_riscv_boot_ctrl;

    localparam int ADDR_W     = 8;
    localparam int RUN_CYCLES = 100;
    localparam int DEPTH      = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   len;
    logic              abort;
    logic              sValid;
    logic [7:0]        sData;
    logic              sReady;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [31:0]       memWdata;
    logic              coreRst;
    logic              busy;
    logic              done;
    logic              err;
    logic [15:0]       cycles;

    int          passCount  = 0;
    int          checkCount = 0;
    logic [31:0] tbMem [DEPTH];
    int          writeAddrs [$];
    logic [7:0]  txBytes [$];
    int          lowCount;
    int          weWhileRun;
    int          cycleNum = 0;
    int          firstLowCycle;
    int          startCycle;

    riscv_boot_ctrl #(.ADDR_W(ADDR_W), .RUN_CYCLES(RUN_CYCLES)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .len_i       (len),
        .abort_i     (abort),
        .s_valid_i   (sValid),
        .s_data_i    (sData),
        .s_ready_o   (sReady),
        .mem_we_o    (memWe),
        .mem_addr_o  (memAddr),
        .mem_wdata_o (memWdata),
        .core_rst_o  (coreRst),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .cycles_o    (cycles)
    );

    // Free-running clock and edge counter used for latency measurement.
    always #5 clk = ~clk;
    always @(posedge clk) cycleNum++;

    // Memory model: capture every write and track how long the core ran.
    always @(negedge clk) begin
        if (memWe) begin
            tbMem[memAddr] = memWdata;
            writeAddrs.push_back(int'(memAddr));
            if (!coreRst) weWhileRun++;
        end
        if (!coreRst) begin
            lowCount++;
            if (firstLowCycle < 0) firstLowCycle = cycleNum;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic clearLog();
        writeAddrs.delete();
        lowCount      = 0;
        weWhileRun    = 0;
        firstLowCycle = -1;
        for (int i = 0; i < DEPTH; i++) tbMem[i] = 32'hDEADBEEF;
    endtask

    task automatic makeBytes(input int n);
        txBytes.delete();
        for (int i = 0; i < n; i++) txBytes.push_back(8'($urandom));
    endtask

    // Expected little-endian word k built from the bytes sent.
    function automatic logic [31:0] expWord(input int k);
        logic [31:0] w = 0;
        for (int j = 0; j < 4; j++) w = w + (32'(txBytes[4*k+j]) << (8*j));
        return w;
    endfunction

    task automatic startSeq(input int lenWords);
        start = 1'b1;
        len   = (ADDR_W+1)'(lenWords);
        tick();
        startCycle = cycleNum;
        start = 1'b0;
        len   = '0;
    endtask

    // Stream the first nBytes of txBytes, optionally with random gaps.
    task automatic applyStimulus(input int nBytes, input bit stall);
        int  idx    = 0;
        int  budget = 0;
        bit  hs;
        while (idx < nBytes && budget < 2000) begin
            sValid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            sData  = txBytes[idx];
            hs     = sValid && sReady;
            tick();
            budget++;
            if (hs) idx++;
        end
        sValid = 1'b0;
        sData  = 8'($urandom);
        checkOutput("bytes_accepted", idx, nBytes);
    endtask

    task automatic waitDone();
        int budget = 0;
        while (!done && budget < 1000) begin
            tick();
            budget++;
        end
        checkOutput("done_reached", done, 1);
    endtask

    task automatic checkWords(input int n);
        checkOutput("write_count", writeAddrs.size(), n);
        for (int k = 0; k < n && k < writeAddrs.size(); k++) begin
            checkOutput("write_addr", writeAddrs[k], k);
            checkOutput("write_word", tbMem[k], expWord(k));
        end
    endtask

    task automatic checkReset();
        checkOutput("rst_core_rst", coreRst, 1);
        checkOutput("rst_s_ready", sReady, 0);
        checkOutput("rst_mem_we", memWe, 0);
        checkOutput("rst_mem_addr", 32'(memAddr), 0);
        checkOutput("rst_mem_wdata", memWdata, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_cycles", 32'(cycles), 0);
    endtask

    initial begin
        int budget;

        rst = 1'b1; start = 1'b0; len = '0; abort = 1'b0; sValid = 1'b0; sData = '0;
        clearLog();
        tick();
        tick();
        checkReset();
        rst = 1'b0;
        tick();

        // Reset in the middle of a load, then a single known instruction.
        makeBytes(8);
        startSeq(2);
        applyStimulus(6, 1'b0);
        rst = 1'b1;
        tick();
        checkReset();
        rst = 1'b0;
        tick();
        clearLog();
        txBytes.delete();
        txBytes.push_back(8'h13); txBytes.push_back(8'h00);
        txBytes.push_back(8'h50); txBytes.push_back(8'h00);
        startSeq(1);
        applyStimulus(4, 1'b0);
        waitDone();
        checkWords(1);
        checkOutput("addi_word", tbMem[0], 32'h00500013);

        // Three words at full rate: latency, run length, completion.
        clearLog();
        makeBytes(12);
        startSeq(3);
        applyStimulus(12, 1'b0);
        waitDone();
        checkWords(3);
        checkOutput("start_to_run", firstLowCycle - startCycle, 4*3 + 1);
        checkOutput("run_length", lowCount, RUN_CYCLES);
        checkOutput("done_cycles", 32'(cycles), RUN_CYCLES);
        checkOutput("done_core_rst", coreRst, 1);
        checkOutput("done_busy", busy, 0);
        checkOutput("we_during_run", weWhileRun, 0);

        // Random stalls on the byte stream.
        clearLog();
        makeBytes(16);
        startSeq(4);
        applyStimulus(16, 1'b1);
        waitDone();
        checkWords(4);
        checkOutput("stall_we_during_run", weWhileRun, 0);
        checkOutput("stall_run_length", lowCount, RUN_CYCLES);

        // Oversized length is rejected; a zero-length start clears the error.
        clearLog();
        startSeq(DEPTH + 1);
        checkOutput("bad_len_err", err, 1);
        checkOutput("bad_len_busy", busy, 0);
        checkOutput("bad_len_done", done, 0);
        checkOutput("bad_len_s_ready", sReady, 0);
        tick();
        tick();
        checkOutput("bad_len_writes", writeAddrs.size(), 0);
        startSeq(0);
        checkOutput("zero_len_err", err, 0);
        checkOutput("zero_len_core_rst", coreRst, 0);
        checkOutput("zero_len_busy", busy, 1);
        checkOutput("zero_len_cycles", 32'(cycles), 0);
        waitDone();
        checkOutput("zero_len_writes", writeAddrs.size(), 0);
        checkOutput("zero_len_run_length", lowCount, RUN_CYCLES);

        // Restart from DONE, then abort in the 50th RUN cycle.
        clearLog();
        makeBytes(8);
        startSeq(2);
        checkOutput("restart_cycles", 32'(cycles), 0);
        applyStimulus(8, 1'b0);
        budget = 0;
        while (coreRst && budget < 100) begin
            tick();
            budget++;
        end
        checkOutput("run_entered", coreRst, 0);
        for (int i = 0; i < 49; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort_core_rst", coreRst, 1);
        checkOutput("abort_err", err, 1);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_cycles", 32'(cycles), 50);
        checkOutput("abort_run_length", lowCount, 50);
        tick();
        tick();
        checkOutput("abort_cycles_held", 32'(cycles), 50);
        checkWords(2);

        // Abort in LOAD right after a word completes: that write still lands.
        clearLog();
        makeBytes(12);
        startSeq(3);
        applyStimulus(4, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("load_abort_err", err, 1);
        checkOutput("load_abort_busy", busy, 0);
        tick();
        checkWords(1);

        // Abort alongside start while idle: the start wins.
        start = 1'b1; abort = 1'b1; len = '0;
        tick();
        start = 1'b0; abort = 1'b0;
        checkOutput("idle_abort_busy", busy, 1);
        checkOutput("idle_abort_err", err, 0);
        waitDone();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
